datapath_pmc: RTL and testbench
===============================

DATAPATH_PMC -- requirements
Module: datapath_pmc

Interface
REQ-001 SHALL have parameter W, default 8: datapath, register, K, memory data and address width (W>=4, power of two).
REQ-002 SHALL have parameter NREG, default 8: register-file depth (power of two, >=2); RA = log2(NREG).
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port cw  input  packed struct: control word with fields sl, il, pcl, mr, mw, b_sel, a_sel, en_alu, ci, fs[2:0], w, sb[RA], sa[RA], da[RA].
REQ-006 SHALL have ports cw_valid input 1 and cw_ready output 1: control-word handshake; word consumed when both are high at a clock edge.
REQ-007 SHALL have port K  input  W: immediate operand.
REQ-008 SHALL have mem_req output 1, mem_we output 1, mem_addr output W, mem_wdata output W, mem_rdata input W, mem_ack input 1: memory request handshake.
REQ-009 SHALL have port I  output  W: instruction register.
REQ-010 SHALL have ports pc output W and alu_status output 4: program counter and latched {N,Z,C,V}.

Function
REQ-011 Operands: A = a_sel ? PC : R[sa]; B = b_sel ? K : R[sb]; register reads are asynchronous and return the pre-edge value (no write bypass).
REQ-012 ALU fs: 000 AND, 001 OR, 010 A+B+ci, 011 A+~B+ci, 100 A<<B[log2W-1:0], 101 A>>B[log2W-1:0] logical, 110 XOR, 111 pass A; result W bits, carry = bit W of the add, wraps modulo 2^W.
REQ-013 With en_alu=0 the ALU result SHALL be 0 and C,V SHALL be 0.
REQ-014 Accepted single-cycle word (mr=0, mw=0, il=0): w writes result to R[da]; pcl loads result into PC; sl loads NZCV (V only meaningful for fs 010/011, else 0); all in the acceptance edge; cw_ready stays 1.
REQ-015 FSM states IDLE, MEM. IDLE->MEM on accepted word with mr, mw or il; MEM->IDLE on the edge where mem_ack=1.
REQ-016 In MEM: mem_req=1, cw_ready=0; mem_addr = il ? PC : B; mem_we = mw; mem_wdata = R[sa]; all latched at acceptance and stable until ack.
REQ-017 On ack edge: mr with w writes mem_rdata to R[da]; il loads I with mem_rdata and, if pcl, PC <= PC+1 (wrap at 2^W); sl/ALU writes are ignored for memory words.
REQ-018 mw and mr both set: mw wins, no register write; il with mw: il wins, mw ignored.
REQ-019 mem_ack while in IDLE SHALL be ignored; cw_valid=0 SHALL change no state.
REQ-020 Minimum memory-word latency: 2 cycles (acceptance, ack in following cycle); cw_ready returns high the cycle after ack.

Reset
REQ-021 rst at an edge SHALL clear all registers, PC, I and alu_status to 0, force IDLE, mem_req=0, mem_we=0, cw_ready=1, overriding any in-flight memory transfer (late ack discarded).

Configuration
REQ-022 Macro DATAPATH_PMC_DEBUG_EN defined: extra output dbg_regs (NREG*W, R[i] at bits [i*W +: W]); undefined: port absent, behaviour otherwise identical.

Structure
REQ-023 Shared package dp_pkg SHALL hold the control-word struct typedef, fs encoding constants and FSM state enum.
REQ-024 One sub-module dp_alu (combinational, W-parametrised) SHALL implement REQ-012/013; register file, PC, IR, status and FSM stay in datapath_pmc.

Verification
REQ-025 W=8: MOV R0,#4 (b_sel, fs=001 with R7=0 not required: use fs=111 on K path via a_sel=0 -- use pass of K by OR with R[sa]=0) and MOV R1,#2, then ADD R2 -> R2=6, SUBS R2 -> R2=2, NZCV=0010.
REQ-026 SUBS R1-R0 (2-4) -> R=0xFE, N=1, C=0; ADDS 0xFF+0x01 -> 0x00, Z=1, C=1; SL 4<<2 -> 0x10.
REQ-027 ST R0 to K=3 with ack delayed 3 cycles -> mem_req/addr=3/wdata=4 stable 3 cycles, cw_ready low throughout; LD R3,#3 returning 4 -> R3=4.
REQ-028 IF at PC=0xFF with mem_rdata=0xA5 -> I=0xA5, PC wraps to 0x00; B with K=2, a_sel, ci=1 -> PC=PC+3.
REQ-029 rst asserted during MEM, ack one cycle later -> no register write, mem_req=0, all state 0.
REQ-030 W=16, NREG=16, DATAPATH_PMC_DEBUG_EN: write R15=0xBEEF -> dbg_regs[255:240]=0xBEEF; repeat REQ-025 under the wider parameters.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types for datapath_pmc: control word, ALU function codes, FSM states.
// Register-address fields are sized for the widest supported register file.
package dp_pkg;

  localparam int DP_RA_MAX = 8;

  localparam logic [2:0] FS_AND  = 3'b000;
  localparam logic [2:0] FS_OR   = 3'b001;
  localparam logic [2:0] FS_ADD  = 3'b010;
  localparam logic [2:0] FS_SUB  = 3'b011;
  localparam logic [2:0] FS_SHL  = 3'b100;
  localparam logic [2:0] FS_SHR  = 3'b101;
  localparam logic [2:0] FS_XOR  = 3'b110;
  localparam logic [2:0] FS_PASS = 3'b111;

  typedef struct packed {
    logic                 sl;
    logic                 il;
    logic                 pcl;
    logic                 mr;
    logic                 mw;
    logic                 b_sel;
    logic                 a_sel;
    logic                 en_alu;
    logic                 ci;
    logic [2:0]           fs;
    logic                 w;
    logic [DP_RA_MAX-1:0] sb;
    logic [DP_RA_MAX-1:0] sa;
    logic [DP_RA_MAX-1:0] da;
  } cw_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational W-bit ALU; carry and overflow are produced only by add/subtract.
module dp_alu
  import dp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   fs_i,
  input  logic         ci_i,
  input  logic         en_i,
  output logic [W-1:0] res_o,
  output logic         c_o,
  output logic         v_o
);
  localparam int SH = $clog2(W);

  logic [W:0]   sum_s;
  logic [W-1:0] bx_s;

  // Subtraction reuses the adder with the B operand inverted.
  always_comb begin
    bx_s  = (fs_i == FS_SUB) ? ~b_i : b_i;
    sum_s = {1'b0, a_i} + {1'b0, bx_s} + {{W{1'b0}}, ci_i};
    res_o = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    if (en_i) begin
      case (fs_i)
        FS_AND:  res_o = a_i & b_i;
        FS_OR:   res_o = a_i | b_i;
        FS_ADD, FS_SUB: begin
          res_o = sum_s[W-1:0];
          c_o   = sum_s[W];
          v_o   = (a_i[W-1] == bx_s[W-1]) && (sum_s[W-1] != a_i[W-1]);
        end
        FS_SHL:  res_o = a_i << b_i[SH-1:0];
        FS_SHR:  res_o = a_i >> b_i[SH-1:0];
        FS_XOR:  res_o = a_i ^ b_i;
        default: res_o = a_i;
      endcase
    end else begin
      res_o = '0;
    end
  end

endmodule

// File: rtl/datapath_pmc.sv
// Microcoded datapath: register file, PC, IR, NZCV and a two-state memory FSM.
// Optional DATAPATH_PMC_DEBUG_EN exposes the register file on dbg_regs.
module datapath_pmc
  import dp_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  cw_t              cw,
  input  logic             cw_valid,
  output logic             cw_ready,
  input  logic [W-1:0]     K,
  output logic             mem_req,
  output logic             mem_we,
  output logic [W-1:0]     mem_addr,
  output logic [W-1:0]     mem_wdata,
  input  logic [W-1:0]     mem_rdata,
  input  logic             mem_ack,
  output logic [W-1:0]     I,
  output logic [W-1:0]     pc,
`ifdef DATAPATH_PMC_DEBUG_EN
  output logic [NREG*W-1:0] dbg_regs,
`endif
  output logic [3:0]       alu_status
);
  localparam int RA = $clog2(NREG);

  logic [W-1:0]  regs_q [NREG];
  state_t        state_q;
  logic [W-1:0]  pc_q, ir_q, mem_addr_q, mem_wdata_q;
  logic [3:0]    status_q;
  logic          cw_ready_q, mem_req_q, mem_we_q;
  logic          op_il_q, op_pcl_q, op_ld_q;
  logic [RA-1:0] op_da_q;

  logic          sa_ok_s, sb_ok_s, da_ok_s, accept_s, mem_op_s;
  logic [W-1:0]  ra_s, rb_s, a_s, b_s, res_s, rf_wd_s;
  logic          c_s, v_s, rf_we_s;
  logic [RA-1:0] rf_wa_s;

  // Out-of-range register addresses read as zero and never write.
  always_comb begin
    sa_ok_s  = int'(cw.sa) < NREG;
    sb_ok_s  = int'(cw.sb) < NREG;
    da_ok_s  = int'(cw.da) < NREG;
    ra_s     = sa_ok_s ? regs_q[cw.sa[RA-1:0]] : '0;
    rb_s     = sb_ok_s ? regs_q[cw.sb[RA-1:0]] : '0;
    a_s      = cw.a_sel ? pc_q : ra_s;
    b_s      = cw.b_sel ? K : rb_s;
    accept_s = cw_valid & cw_ready_q;
    mem_op_s = cw.mr | cw.mw | cw.il;
  end

  dp_alu #(.W(W)) u_alu (
    .a_i  (a_s),
    .b_i  (b_s),
    .fs_i (cw.fs),
    .ci_i (cw.ci),
    .en_i (cw.en_alu),
    .res_o(res_s),
    .c_o  (c_s),
    .v_o  (v_s)
  );

  // Register-file write port: ALU result on acceptance, load data on ack.
  always_comb begin
    rf_we_s = 1'b0;
    rf_wa_s = cw.da[RA-1:0];
    rf_wd_s = res_s;
    if (state_q == ST_MEM) begin
      rf_we_s = mem_ack & op_ld_q;
      rf_wa_s = op_da_q;
      rf_wd_s = mem_rdata;
    end else begin
      rf_we_s = accept_s & ~mem_op_s & cw.w & da_ok_s;
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (rf_we_s) begin
      regs_q[rf_wa_s] <= rf_wd_s;
    end
  end

  // Control FSM with PC, IR, status and registered memory interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      status_q    <= 4'b0000;
      cw_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      op_il_q     <= 1'b0;
      op_pcl_q    <= 1'b0;
      op_ld_q     <= 1'b0;
      op_da_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && mem_op_s) begin
            state_q     <= ST_MEM;
            cw_ready_q  <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= cw.mw & ~cw.il;
            mem_addr_q  <= cw.il ? pc_q : b_s;
            mem_wdata_q <= ra_s;
            op_il_q     <= cw.il;
            op_pcl_q    <= cw.pcl;
            op_ld_q     <= cw.mr & ~cw.mw & ~cw.il & cw.w & da_ok_s;
            op_da_q     <= cw.da[RA-1:0];
          end else if (accept_s) begin
            if (cw.pcl) pc_q <= res_s;
            if (cw.sl) status_q <= {res_s[W-1], res_s == '0, c_s, v_s};
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            state_q    <= ST_IDLE;
            cw_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            if (op_il_q) begin
              ir_q <= mem_rdata;
              if (op_pcl_q) pc_q <= pc_q + {{(W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cw_ready   = cw_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign I          = ir_q;
  assign pc         = pc_q;
  assign alu_status = status_q;

`ifdef DATAPATH_PMC_DEBUG_EN
  for (genvar g = 0; g < NREG; g++) begin : g_dbg
    assign dbg_regs[g*W +: W] = regs_q[g];
  end
`endif

endmodule

// File: tb/tb_datapath_pmc.sv
// Self-checking bench for datapath_pmc: directed table, memory sequences, random ALU words.
module tb_datapath_pmc;
  import dp_pkg::*;

`ifdef DATAPATH_PMC_DEBUG_EN
  localparam int W = 16;
  localparam int NREG = 16;
`else
  localparam int W = 8;
  localparam int NREG = 8;
`endif
  localparam logic [W-1:0] ALL1 = '1;

  logic clk = 1'b0, rst = 1'b1, cw_valid = 1'b0, cw_ready, mem_req, mem_we, mem_ack = 1'b0;
  cw_t cw = '0;
  logic [W-1:0] K = '0, mem_addr, mem_wdata, mem_rdata = '0, ir_o, pc;
  logic [3:0] alu_status;
`ifdef DATAPATH_PMC_DEBUG_EN
  logic [NREG*W-1:0] dbg_regs;
`endif

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  datapath_pmc #(.W(W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .cw(cw), .cw_valid(cw_valid), .cw_ready(cw_ready), .K(K),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .I(ir_o), .pc(pc),
`ifdef DATAPATH_PMC_DEBUG_EN
    .dbg_regs(dbg_regs),
`endif
    .alu_status(alu_status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic cw_t acw(input int fs, input int da, input int sa, input int sb,
                              input bit a_sel, input bit b_sel, input bit ci, input bit en,
                              input bit w, input bit sl, input bit pcl);
    cw_t c = '0;
    c.fs = 3'(fs); c.da = DP_RA_MAX'(da); c.sa = DP_RA_MAX'(sa); c.sb = DP_RA_MAX'(sb);
    c.a_sel = a_sel; c.b_sel = b_sel; c.ci = ci; c.en_alu = en; c.w = w; c.sl = sl; c.pcl = pcl;
    return c;
  endfunction

  // Copy R[rd] into PC with a pass-A word and return what PC shows.
  task automatic read_reg(input int rd, output logic [W-1:0] val);
    cw = acw(7, 0, rd, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cw_valid = 1'b1;
    tick();
    val = pc;
    cw_valid = 1'b0;
  endtask

  // Reference ALU from the arithmetic definition of each function.
  function automatic void ref_alu(input int fs, input longint a, input longint b, input int ci,
                                  input bit en, output longint r, output int c, output int v);
    longint m = longint'(1) << W;
    longint bb, s, sv, sa_, sb_;
    r = 0; c = 0; v = 0;
    if (!en) return;
    case (fs)
      0: r = a & b;
      1: r = a | b;
      2, 3: begin
        bb  = (fs == 3) ? (m - 1 - b) : b;
        s   = a + bb + ci;
        r   = s % m;
        c   = (s >= m) ? 1 : 0;
        sa_ = (a >= m/2) ? a - m : a;
        sb_ = (bb >= m/2) ? bb - m : bb;
        sv  = sa_ + sb_ + ci;
        v   = (sv >= m/2 || sv < -(m/2)) ? 1 : 0;
      end
      4: r = (a << (b % W)) % m;
      5: r = a >> (b % W);
      6: r = a ^ b;
      default: r = a;
    endcase
  endfunction

  typedef struct {
    string nm; int fs, da, sa, sb; bit a_sel, b_sel, ci, en, sl;
    logic [W-1:0] k, exp; bit chk_st; logic [3:0] exp_st;
  } vec_t;

  function automatic vec_t mkv(input string nm, input int fs, input int da, input int sa, input int sb,
                               input bit b_sel, input bit ci, input bit en, input bit sl,
                               input logic [W-1:0] k, input logic [W-1:0] exp,
                               input bit chk_st, input logic [3:0] exp_st);
    vec_t t;
    t.nm = nm; t.fs = fs; t.da = da; t.sa = sa; t.sb = sb; t.a_sel = 1'b0; t.b_sel = b_sel;
    t.ci = ci; t.en = en; t.sl = sl; t.k = k; t.exp = exp; t.chk_st = chk_st; t.exp_st = exp_st;
    return t;
  endfunction

  vec_t tbl[13];
  logic [W-1:0] rv;
  longint m_r[NREG];
  longint m_pc;
  int m_st;

  initial begin
    tbl[0]  = mkv("mov_r0",   1, 0, 7, 0, 1, 0, 1, 0, W'(4), W'(4), 0, 4'b0000);
    tbl[1]  = mkv("mov_r1",   1, 1, 7, 0, 1, 0, 1, 0, W'(2), W'(2), 0, 4'b0000);
    tbl[2]  = mkv("add_r2",   2, 2, 0, 1, 0, 0, 1, 0, '0, W'(6), 0, 4'b0000);
    tbl[3]  = mkv("subs_r2",  3, 2, 2, 0, 0, 1, 1, 1, '0, W'(2), 1, 4'b0010);
    tbl[4]  = mkv("subs_neg", 3, 3, 1, 0, 0, 1, 1, 1, '0, ALL1 - W'(1), 1, 4'b1000);
    tbl[5]  = mkv("mov_r4",   1, 4, 7, 0, 1, 0, 1, 0, ALL1, ALL1, 0, 4'b0000);
    tbl[6]  = mkv("mov_r5",   1, 5, 7, 0, 1, 0, 1, 0, W'(1), W'(1), 0, 4'b0000);
    tbl[7]  = mkv("adds_wrap",2, 6, 4, 5, 0, 0, 1, 1, '0, '0, 1, 4'b0110);
    tbl[8]  = mkv("shl",      4, 6, 0, 0, 1, 0, 1, 1, W'(2), W'(16), 1, 4'b0000);
    tbl[9]  = mkv("shr",      5, 6, 0, 0, 1, 0, 1, 0, W'(1), W'(2), 0, 4'b0000);
    tbl[10] = mkv("xor",      6, 6, 0, 1, 0, 0, 1, 0, '0, W'(6), 0, 4'b0000);
    tbl[11] = mkv("and_zero", 0, 6, 0, 1, 0, 0, 1, 1, '0, '0, 1, 4'b0100);
    tbl[12] = mkv("alu_off",  2, 6, 4, 5, 0, 0, 0, 1, '0, '0, 1, 4'b0100);

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", pc, 0); chk("rst_ir", ir_o, 0); chk("rst_st", alu_status, 0);
    chk("rst_ready", cw_ready, 1); chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0);

    for (int i = 0; i < 13; i++) begin
      cw = acw(tbl[i].fs, tbl[i].da, tbl[i].sa, tbl[i].sb, tbl[i].a_sel, tbl[i].b_sel,
               tbl[i].ci, tbl[i].en, 1'b1, tbl[i].sl, 1'b0);
      K = tbl[i].k;
      cw_valid = 1'b1;
      tick();
      cw_valid = 1'b0;
      if (tbl[i].chk_st) chk({tbl[i].nm, "_nzcv"}, alu_status, tbl[i].exp_st);
      read_reg(tbl[i].da, rv);
      chk(tbl[i].nm, rv, tbl[i].exp);
    end

    // Store with ack held off for three cycles; K changes mid-transfer.
    cw = '0; cw.mw = 1'b1; cw.b_sel = 1'b1; cw.sa = '0; K = W'(3);
    cw_valid = 1'b1;
    tick();
    cw_valid = 1'b0; K = W'(9);
    for (int i = 0; i < 3; i++) begin
      chk("st_req", mem_req, 1); chk("st_addr", mem_addr, 3); chk("st_wdata", mem_wdata, 4);
      chk("st_we", mem_we, 1); chk("st_ready", cw_ready, 0);
      if (i < 2) tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_done_req", mem_req, 0); chk("st_done_ready", cw_ready, 1);

    // Ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = W'(8'h77);
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", mem_req, 0); chk("idle_ack_ir", ir_o, 0);

    // Load R3 from address 3.
    cw = '0; cw.mr = 1'b1; cw.w = 1'b1; cw.da = DP_RA_MAX'(3); cw.b_sel = 1'b1; K = W'(3);
    cw_valid = 1'b1;
    tick();
    cw_valid = 1'b0;
    chk("ld_addr", mem_addr, 3); chk("ld_we", mem_we, 0); chk("ld_req", mem_req, 1);
    mem_rdata = W'(4); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    read_reg(3, rv);
    chk("ld_r3", rv, 4);

    // mr and mw together: store wins, no register write.
    cw = '0; cw.mr = 1'b1; cw.mw = 1'b1; cw.w = 1'b1; cw.da = DP_RA_MAX'(3); cw.b_sel = 1'b1;
    K = W'(5); cw_valid = 1'b1;
    tick();
    cw_valid = 1'b0;
    chk("mrmw_we", mem_we, 1);
    mem_rdata = W'(8'h55); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    read_reg(3, rv);
    chk("mrmw_r3", rv, 4);

    // Fetch at PC=all-ones: PC wraps, fetch overrides the store flag.
    cw = acw(1, 0, 7, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); K = ALL1; cw_valid = 1'b1;
    tick();
    chk("if_setpc", pc, ALL1);
    cw = '0; cw.il = 1'b1; cw.pcl = 1'b1; cw.mw = 1'b1;
    tick();
    cw_valid = 1'b0;
    chk("if_addr", mem_addr, ALL1); chk("if_we", mem_we, 0);
    mem_rdata = W'(8'hA5); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("if_ir", ir_o, W'(8'hA5)); chk("if_pc_wrap", pc, 0);

    // Relative branch PC+K+1, then the same word with cw_valid low.
    cw = acw(2, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); K = W'(2); cw_valid = 1'b1;
    tick();
    chk("branch_pc", pc, 3);
    cw_valid = 1'b0;
    tick();
    chk("novalid_pc", pc, 3);

    // Reset during a load; the late ack must be discarded.
    cw = '0; cw.mr = 1'b1; cw.w = 1'b1; cw.da = DP_RA_MAX'(2); cw.b_sel = 1'b1; K = W'(3);
    cw_valid = 1'b1;
    tick();
    cw_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_rdata = W'(8'h99); mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rstmem_req", mem_req, 0); chk("rstmem_ready", cw_ready, 1); chk("rstmem_pc", pc, 0);
    chk("rstmem_ir", ir_o, 0); chk("rstmem_st", alu_status, 0);
    read_reg(2, rv);
    chk("rstmem_r2", rv, 0);
    read_reg(0, rv);
    chk("rstmem_r0", rv, 0);

`ifdef DATAPATH_PMC_DEBUG_EN
    cw = acw(1, NREG-1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); K = W'(16'hBEEF);
    cw_valid = 1'b1;
    tick();
    cw_valid = 1'b0;
    chk("dbg_rtop", dbg_regs[(NREG-1)*W +: W], W'(16'hBEEF));
`endif

    // Random single-cycle words against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) m_r[i] = 0;
    m_pc = 0; m_st = 0;
    for (int n = 0; n < 300; n++) begin
      int fs = $urandom_range(0, 7);
      int da = $urandom_range(0, NREG-1);
      int sa = $urandom_range(0, NREG-1);
      int sb = $urandom_range(0, NREG-1);
      bit as = 1'($urandom), bs = 1'($urandom), ci = 1'($urandom), w = 1'($urandom);
      bit sl = 1'($urandom), pcl = ($urandom_range(0, 3) == 0), en = ($urandom_range(0, 7) != 0);
      bit vld = ($urandom_range(0, 4) != 0);
      logic [W-1:0] k = W'($urandom);
      longint a, b, r;
      int c, v;
      cw = acw(fs, da, sa, sb, as, bs, ci, en, w, sl, pcl); K = k; cw_valid = vld;
      a = as ? m_pc : m_r[sa];
      b = bs ? longint'(k) : m_r[sb];
      tick();
      if (vld) begin
        ref_alu(fs, a, b, ci, en, r, c, v);
        if (w) m_r[da] = r;
        if (pcl) m_pc = r;
        if (sl) m_st = ((r >= (longint'(1) << (W-1))) ? 8 : 0) + ((r == 0) ? 4 : 0) + c*2 + v;
      end
      chk("rnd_pc", pc, m_pc);
      chk("rnd_nzcv", alu_status, m_st);
    end
    cw_valid = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      read_reg(i, rv);
      chk("rnd_reg", rv, m_r[i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
